pa_fpu_pipe_ctrl: RTL and testbench

Parametrised valid/stall controller for the FPU back-end pipeline, from EX2 to EX(1+STAGES).
- Tracks a valid bit and an EU tag per stage.
- Generates per-stage result-bus writeback requests and the backward stall chain.
- Handles RTU EX2 cancel (with retire-with-wb qualification) and full-pipe flush.
- Produces the ICG enable, an in-flight count and the no-op indication.
- Sits between the EX1 issue logic and the FALU/FMAU/FDSU datapaths and the frbus arbiter; replaces the fixed 3-stage control.

---
 rtl/pa_fpu_pkg.sv | 20 ++
 rtl/pa_fpu_pipe_stage.sv | 41 ++++
 rtl/pa_fpu_pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pa_fpu_pipe_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu_pkg.sv
// rtl/pa_fpu_pkg.sv - shared FPU pipe-control defaults, EU tags and helpers
package pa_fpu_pkg;

    localparam int STAGES_DEF = 3;
    localparam int EU_W_DEF   = 3;

    localparam logic [2:0] EU_FALU = 3'b001;
    localparam logic [2:0] EU_FMAU = 3'b010;
    localparam logic [2:0] EU_FDSU = 3'b100;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pa_fpu_pipe_stage.sv
// rtl/pa_fpu_pipe_stage.sv - one valid+EU-tag pipeline stage with clear/load/hold
module pa_fpu_pipe_stage #(
    parameter int EU_W = 3
) (
    input  logic            ex2_ctrl_clk,
    input  logic            cpurst_b,
    input  logic            stage_clr,
    input  logic            stage_load,
    input  logic            load_vld,
    input  logic [EU_W-1:0] load_eu,
    output logic            vld,
    output logic [EU_W-1:0] eu,
    output logic            vld_nxt
);

    logic [EU_W-1:0] eu_nxt;

    // The tag is zeroed whenever the slot is empty so an idle stage never shows a stale EU.
    always_comb begin
        vld_nxt = vld;
        eu_nxt  = eu;
        if (stage_clr) begin
            vld_nxt = 1'b0;
            eu_nxt  = '0;
        end else if (stage_load) begin
            vld_nxt = load_vld;
            eu_nxt  = load_vld ? load_eu : '0;
        end
    end

    always_ff @(posedge ex2_ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            vld <= 1'b0;
            eu  <= '0;
        end else begin
            vld <= vld_nxt;
            eu  <= eu_nxt;
        end
    end

endmodule

// File: rtl/pa_fpu_pipe_ctrl.sv
// rtl/pa_fpu_pipe_ctrl.sv - FPU back-end valid/stall controller for EX2..EX(1+STAGES)
module pa_fpu_pipe_ctrl
    import pa_fpu_pkg::*;
#(
    parameter int STAGES = STAGES_DEF,
    parameter int EU_W   = EU_W_DEF,
    parameter int CNT_W  = 4
) (
    input  logic                   ex2_ctrl_clk,
    input  logic                   cpurst_b,
    input  logic                   ex1_inst_vld,
    input  logic                   ex1_gateclk_vld,
    input  logic                   ex1_unit_stall,
    input  logic                   ex1_cancel,
    input  logic                   ex1_no_pipe,
    input  logic [EU_W-1:0]        ex1_eu_sel,
    input  logic                   rtu_ex2_cancel,
    input  logic                   rtu_ex2_stall,
    input  logic                   flush,
    input  logic [STAGES-1:0]      stage_wb,
    input  logic [STAGES-1:0]      stage_hold,
    input  logic [STAGES-1:0]      wb_grant,
    output logic                   ex1_stall,
    output logic [STAGES-1:0]      stage_vld,
    output logic [STAGES-1:0]      stage_stall,
    output logic [STAGES-1:0]      wb_req,
    output logic [STAGES*EU_W-1:0] stage_eu,
    output logic                   ex2_cancel,
    output logic                   ctrl_clk_en,
    output logic [CNT_W-1:0]       inflight_cnt,
    output logic                   pipe_empty
);

    logic [STAGES-1:0] stall;
    logic [STAGES-1:0] vld_nxt;
    logic              retire_wb;

    // A stage without a pending wb only stalls when the stage ahead of it does.
    always_comb begin
        stall = '0;
        stall[STAGES-1] = stage_vld[STAGES-1] && (!stage_wb[STAGES-1] || !wb_grant[STAGES-1])
                          || stage_hold[STAGES-1];
        for (int i = STAGES - 2; i >= 0; i--) begin
            stall[i] = stage_vld[i] && (stage_wb[i] && !wb_grant[i] || !stage_wb[i] && stall[i+1])
                       || stage_hold[i];
        end
    end

    assign stage_stall = stall;
    assign ex1_stall   = ex1_gateclk_vld &&
                         ((stall[0] && !ex1_no_pipe) || ex1_unit_stall || rtu_ex2_stall);
    assign ex2_cancel  = stage_vld[0] && rtu_ex2_cancel && retire_wb;
    assign ctrl_clk_en = ex1_gateclk_vld || (|stage_vld) || flush;
    assign pipe_empty  = !ex1_inst_vld && !(|stage_vld);

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic            clr;
        logic            ld_v;
        logic [EU_W-1:0] ld_e;

        if (g == 0) begin : g_head
            assign clr  = flush || ex2_cancel;
            assign ld_v = ex1_inst_vld && !ex1_cancel && !ex1_stall && !ex1_no_pipe;
            assign ld_e = ex1_eu_sel;
        end else begin : g_tail
            assign clr  = flush;
            assign ld_v = stage_vld[g-1] && !stage_wb[g-1] && !stall[g-1]
                          && !((g == 1) && ex2_cancel);
            assign ld_e = stage_eu[(g-1)*EU_W +: EU_W];
        end

        pa_fpu_pipe_stage #(.EU_W(EU_W)) u_stage (
            .ex2_ctrl_clk (ex2_ctrl_clk),
            .cpurst_b     (cpurst_b),
            .stage_clr    (clr),
            .stage_load   (!stall[g]),
            .load_vld     (ld_v),
            .load_eu      (ld_e),
            .vld          (stage_vld[g]),
            .eu           (stage_eu[g*EU_W +: EU_W]),
            .vld_nxt      (vld_nxt[g])
        );

        assign wb_req[g] = stage_vld[g] && stage_wb[g] && !flush && !((g == 0) && ex2_cancel);
    end

    always_ff @(posedge ex2_ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            retire_wb <= 1'b0;
        end else if (flush) begin
            retire_wb <= 1'b0;
        end else if (!rtu_ex2_stall) begin
            retire_wb <= ex1_inst_vld && !stall[0];
        end
    end

    always_ff @(posedge ex2_ctrl_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            inflight_cnt <= '0;
        end else begin
            inflight_cnt <= CNT_W'(popcount(8'(vld_nxt)));
        end
    end

endmodule

// File: tb/tb_pa_fpu_pipe_ctrl.sv
// tb/tb_pa_fpu_pipe_ctrl.sv - self-checking bench for pa_fpu_pipe_ctrl (3- and 5-stage builds)
module tb_pa_fpu_pipe_ctrl;

    typedef struct {
        string    name;
        bit       ivld, gvld, ecan, ustall, nopipe;
        bit [2:0] eu;
        bit       rcan, rstall, fl;
        bit [2:0] wb, hold, gnt;
        bit       acc;
        bit [2:0] e_vld, e_req;
        bit       e_ex1s, e_ex2c;
        bit [3:0] e_cnt;
        bit       e_empty, e_cke;
    } vec_t;

    logic clk = 1'b0;
    logic cpurst_b;
    logic ivld, gvld, ustall, ecan, nopipe, rcan, rstall, fl;
    logic [2:0] eu;

    logic [2:0] wb3, hold3, gnt3, vld3, stl3, req3;
    logic [8:0] eu3;
    logic [3:0] cnt3;
    logic       ex1s3, ex2c3, cke3, emp3;

    logic [4:0]  wb5, hold5, gnt5, vld5, stl5, req5;
    logic [14:0] eu5;
    logic [3:0]  cnt5;
    logic        ex1s5, ex2c5, cke5, emp5;

    int checks   = 0;
    int failures = 0;
    vec_t     tbl[$];
    bit [2:0] sb[$];

    always #5 clk = ~clk;

    pa_fpu_pipe_ctrl #(.STAGES(3), .EU_W(3), .CNT_W(4)) u_dut3 (
        .ex2_ctrl_clk(clk), .cpurst_b(cpurst_b), .ex1_inst_vld(ivld), .ex1_gateclk_vld(gvld),
        .ex1_unit_stall(ustall), .ex1_cancel(ecan), .ex1_no_pipe(nopipe), .ex1_eu_sel(eu),
        .rtu_ex2_cancel(rcan), .rtu_ex2_stall(rstall), .flush(fl), .stage_wb(wb3),
        .stage_hold(hold3), .wb_grant(gnt3), .ex1_stall(ex1s3), .stage_vld(vld3),
        .stage_stall(stl3), .wb_req(req3), .stage_eu(eu3), .ex2_cancel(ex2c3),
        .ctrl_clk_en(cke3), .inflight_cnt(cnt3), .pipe_empty(emp3)
    );

    pa_fpu_pipe_ctrl #(.STAGES(5), .EU_W(3), .CNT_W(4)) u_dut5 (
        .ex2_ctrl_clk(clk), .cpurst_b(cpurst_b), .ex1_inst_vld(ivld), .ex1_gateclk_vld(gvld),
        .ex1_unit_stall(ustall), .ex1_cancel(ecan), .ex1_no_pipe(nopipe), .ex1_eu_sel(eu),
        .rtu_ex2_cancel(rcan), .rtu_ex2_stall(rstall), .flush(fl), .stage_wb(wb5),
        .stage_hold(hold5), .wb_grant(gnt5), .ex1_stall(ex1s5), .stage_vld(vld5),
        .stage_stall(stl5), .wb_req(req5), .stage_eu(eu5), .ex2_cancel(ex2c5),
        .ctrl_clk_en(cke5), .inflight_cnt(cnt5), .pipe_empty(emp5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string n, input bit iv, gv, ec, us, np, input bit [2:0] e,
                       input bit rc, rs, f, input bit [2:0] w, h, g, input bit ac,
                       input bit [2:0] ev, er, input bit es, ex2, input bit [3:0] ecnt,
                       input bit eem, eck);
        vec_t v;
        v.name = n; v.ivld = iv; v.gvld = gv; v.ecan = ec; v.ustall = us; v.nopipe = np;
        v.eu = e; v.rcan = rc; v.rstall = rs; v.fl = f; v.wb = w; v.hold = h; v.gnt = g;
        v.acc = ac; v.e_vld = ev; v.e_req = er; v.e_ex1s = es; v.e_ex2c = ex2;
        v.e_cnt = ecnt; v.e_empty = eem; v.e_cke = eck;
        tbl.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        bit [2:0] exp_eu;
        ivld = v.ivld; gvld = v.gvld; ecan = v.ecan; ustall = v.ustall; nopipe = v.nopipe;
        eu = v.eu; rcan = v.rcan; rstall = v.rstall; fl = v.fl;
        wb3 = v.wb; hold3 = v.hold; gnt3 = v.gnt;
        @(negedge clk);
        chk({v.name, " stage_vld"}, 32'(vld3), 32'(v.e_vld));
        chk({v.name, " wb_req"}, 32'(req3), 32'(v.e_req));
        chk({v.name, " ex1_stall"}, 32'(ex1s3), 32'(v.e_ex1s));
        chk({v.name, " ex2_cancel"}, 32'(ex2c3), 32'(v.e_ex2c));
        chk({v.name, " inflight_cnt"}, 32'(cnt3), 32'(v.e_cnt));
        chk({v.name, " pipe_empty"}, 32'(emp3), 32'(v.e_empty));
        chk({v.name, " ctrl_clk_en"}, 32'(cke3), 32'(v.e_cke));
        if (req3[2] && gnt3[2]) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s sb_underflow: got retire with nothing expected", v.name);
            end else begin
                exp_eu = sb.pop_front();
                chk({v.name, " retire_eu"}, 32'(eu3[8:6]), 32'(exp_eu));
            end
        end
        if (v.e_ex2c && sb.size() > 0) sb.delete(sb.size() - 1);
        if (v.fl) sb.delete();
        if (v.acc) sb.push_back(v.eu);
        @(posedge clk);
        #1;
    endtask

    task automatic lat5(input bit use_hold, output int n);
        int  holds;
        bit  found;
        ivld = 1; gvld = 1; eu = 3'b010;
        @(posedge clk);
        #1;
        ivld = 0; gvld = 0;
        n = 1; holds = 2; found = 0;
        for (int k = 0; k < 20; k++) begin
            if (use_hold && vld5[1] && holds > 0) begin
                hold5 = 5'b00010;
                holds--;
            end else begin
                hold5 = 5'b00000;
            end
            @(negedge clk);
            if (req5[4]) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!found) n = 99;
    endtask

    initial begin
        int n;
        cpurst_b = 0;
        {ivld, gvld, ustall, ecan, nopipe, rcan, rstall, fl} = '0;
        eu = '0; wb3 = '0; hold3 = '0; gnt3 = 3'b111;
        wb5 = 5'b10000; hold5 = '0; gnt5 = 5'b11111;

        //   name  iv gv ec us np eu      rc rs fl wb      hold    gnt     ac e_vld   e_req   s  x2 cnt  em ck
        add("r0",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("a0",  1, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b100, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("a1",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b001, 3'b000, 0, 0, 4'd1, 0, 1);
        add("a2",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b010, 3'b000, 0, 0, 4'd1, 0, 1);
        add("a3",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b100, 3'b100, 0, 0, 4'd1, 0, 1);
        add("a4",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("b0",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("b1",  1, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b100, 3'b000, 3'b111, 1, 3'b001, 3'b000, 0, 0, 4'd1, 0, 1);
        add("b2",  1, 1, 0, 0, 0, 3'b100, 0, 0, 0, 3'b100, 3'b000, 3'b011, 1, 3'b011, 3'b000, 0, 0, 4'd2, 0, 1);
        add("b3",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 3'b011, 0, 3'b111, 3'b100, 1, 0, 4'd3, 0, 1);
        add("b4",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 3'b011, 0, 3'b111, 3'b100, 1, 0, 4'd3, 0, 1);
        add("b5",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 3'b011, 0, 3'b111, 3'b100, 1, 0, 4'd3, 0, 1);
        add("b6",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 3'b111, 1, 3'b111, 3'b100, 0, 0, 4'd3, 0, 1);
        add("b7",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b111, 3'b100, 0, 0, 4'd3, 0, 1);
        add("b8",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b110, 3'b100, 0, 0, 4'd2, 0, 1);
        add("b9",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b100, 3'b100, 0, 0, 4'd1, 0, 1);
        add("b10", 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("c0",  1, 1, 0, 0, 1, 3'b001, 0, 0, 0, 3'b000, 3'b001, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("c1",  1, 1, 0, 0, 1, 3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("c2",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b001, 3'b111, 0, 3'b000, 3'b000, 1, 0, 4'd0, 0, 1);
        add("c3",  1, 1, 0, 1, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 1, 0, 4'd0, 0, 1);
        add("c4",  1, 1, 1, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("c5",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("d0",  1, 1, 0, 0, 0, 3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("d1",  0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'b001, 3'b000, 3'b111, 0, 3'b001, 3'b000, 0, 1, 4'd1, 0, 1);
        add("d2",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("d3",  1, 0, 0, 0, 0, 3'b001, 0, 1, 0, 3'b000, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 4'd0, 0, 0);
        add("d4",  0, 0, 0, 0, 0, 3'b000, 1, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b001, 3'b000, 0, 0, 4'd1, 0, 1);
        add("d5",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b010, 3'b000, 0, 0, 4'd1, 0, 1);
        add("d6",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b100, 3'b000, 3'b111, 0, 3'b100, 3'b100, 0, 0, 4'd1, 0, 1);
        add("d7",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);
        add("e0",  1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 3'b000, 3'b000, 0, 0, 4'd0, 0, 1);
        add("e1",  1, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 3'b001, 3'b000, 0, 0, 4'd1, 0, 1);
        add("e2",  1, 1, 0, 0, 0, 3'b100, 0, 0, 0, 3'b000, 3'b000, 3'b111, 1, 3'b011, 3'b000, 0, 0, 4'd2, 0, 1);
        add("e3",  0, 0, 0, 0, 0, 3'b000, 0, 0, 1, 3'b111, 3'b000, 3'b111, 0, 3'b111, 3'b000, 0, 0, 4'd3, 0, 1);
        add("e4",  0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b111, 0, 3'b000, 3'b000, 0, 0, 4'd0, 1, 0);

        #12;
        chk("in_reset stage_vld", 32'(vld3), 32'h0);
        chk("in_reset inflight_cnt", 32'(cnt3), 32'h0);
        chk("in_reset pipe_empty", 32'(emp3), 32'h1);
        chk("in_reset ctrl_clk_en", 32'(cke3), 32'h0);
        @(posedge clk);
        #1;
        cpurst_b = 1;

        foreach (tbl[i]) apply(tbl[i]);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        // Asynchronous reset with two instructions in flight and wb pending everywhere.
        ivld = 1; gvld = 1; eu = 3'b001; wb3 = 3'b000; gnt3 = 3'b111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        ivld = 0; gvld = 0; wb3 = 3'b111;
        @(negedge clk);
        chk("pre_reset stage_vld", 32'(vld3), 32'h3);
        cpurst_b = 0;
        #1;
        chk("mid_reset stage_vld", 32'(vld3), 32'h0);
        chk("mid_reset wb_req", 32'(req3), 32'h0);
        chk("mid_reset inflight_cnt", 32'(cnt3), 32'h0);
        @(posedge clk);
        #1;
        cpurst_b = 1;
        wb3 = 3'b000;

        lat5(0, n);
        chk("s5 latency", 32'(n), 32'd5);
        chk("s5 exit stage_vld", 32'(vld5), 32'h10);
        chk("s5 exit inflight_cnt", 32'(cnt5), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("s5 drained stage_vld", 32'(vld5), 32'h0);
        @(posedge clk);
        #1;
        lat5(1, n);
        chk("s5 hold latency", 32'(n), 32'd7);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

endmodule
